spike_window_classifier: RTL and testbench

//  Downstream of the SNN core. Counts spikes per output neuron over a fixed window of

---
 rtl/spike_window_classifier.sv | 140 ++++++++++++++
 tb/tb_spike_window_classifier.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_classifier.sv
// Spike-count window classifier: counts spikes per output neuron over WINDOW cycles and reports
// the highest-count neuron (plus a tie flag) over valid/ready. Optional macro: CLASSIFIER_COUNTS_OUT_EN.
module spike_window_classifier #(
  parameter int N_OUT  = 2,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 64,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_OUT-1:0] spikes_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [IDX_W-1:0] winner,
  output logic             tie
`ifdef CLASSIFIER_COUNTS_OUT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] counts
`endif
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  // Handshake: a result transfers on any rising edge where result_valid && result_ready;
  // result_valid, winner and tie stay stable until that edge.
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] cnt_d [N_OUT];
  logic [WIN_W-1:0] win_q, win_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic             tie_q, tie_d;

  logic [CNT_W-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
  logic             tie_c;
  logic             seen_max;

  // Strict '>' keeps the lowest index when several neurons share the maximum.
  always_comb begin
    max_val  = cnt_q[0];
    max_idx  = '0;
    tie_c    = 1'b0;
    seen_max = 1'b0;
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt_q[i] > max_val) begin
        max_val = cnt_q[i];
        max_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (cnt_q[i] == max_val) begin
        if (seen_max) tie_c = 1'b1;
        seen_max = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
          win_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        for (int i = 0; i < N_OUT; i++) begin
          if (spikes_in[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        win_d = win_q + WIN_W'(1);
        if (win_q == WIN_W'(WINDOW - 1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        winner_d = max_idx;
        tie_d    = tie_c;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (result_ready) begin
          if (start) begin
            for (int i = 0; i < N_OUT; i++) cnt_d[i] = '0;
            win_d   = '0;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_ACCUM) || (state_d == S_DECIDE);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign winner       = winner_q;
  assign tie          = tie_q;

`ifdef CLASSIFIER_COUNTS_OUT_EN
  // Counters only move in ACCUM, so this is frozen from DECIDE until the next start.
  always_comb begin
    counts = '0;
    for (int i = 0; i < N_OUT; i++) counts[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed, table-driven bench for spike_window_classifier: default instance plus a CNT_W=4
// instance for saturation; hand-written sequences cover reset mid-window and HOLD back-pressure.
module tb_spike_window_classifier;

  localparam int WINDOW = 64;

  logic       clk;
  logic       reset;
  logic       start, start2;
  logic [1:0] spikes, spikes2;
  logic       ready, ready2;
  logic       busy, busy2;
  logic       valid, valid2;
  logic [0:0] winner, winner2;
  logic       tie, tie2;
`ifdef CLASSIFIER_COUNTS_OUT_EN
  logic [15:0] counts;
  logic [7:0]  counts2;
`endif

  int checks   = 0;
  int failures = 0;

  spike_window_classifier #(.N_OUT(2), .CNT_W(8), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset(reset), .start(start), .spikes_in(spikes),
    .busy(busy), .result_valid(valid), .result_ready(ready),
    .winner(winner), .tie(tie)
`ifdef CLASSIFIER_COUNTS_OUT_EN
    , .counts(counts)
`endif
  );

  spike_window_classifier #(.N_OUT(2), .CNT_W(4), .WINDOW(WINDOW)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .spikes_in(spikes2),
    .busy(busy2), .result_valid(valid2), .result_ready(ready2),
    .winner(winner2), .tie(tie2)
`ifdef CLASSIFIER_COUNTS_OUT_EN
    , .counts(counts2)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int exp_winner;
    int exp_tie;
    int exp_c0;
    int exp_c1;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // k is the ACCUM cycle index 0..WINDOW-1
  function automatic logic [1:0] gen(input int mode, input int k);
    logic s0, s1;
    s0 = 1'b0;
    s1 = 1'b0;
    case (mode)
      0: s0 = 1'b1;
      1: begin s1 = (k % 2 == 0); s0 = (k % 4 == 0); end
      3: s1 = 1'b1;
      4: begin s0 = 1'b1; s1 = 1'b1; end
      5: begin s0 = (k < 40); s1 = (k >= 24); end
      6: begin s0 = (k < 40); s1 = (k >= 23); end
      7: begin s0 = 1'b1; s1 = (k < 20); end
      default: ;
    endcase
    return {s1, s0};
  endfunction

  // Drives the WINDOW accumulation cycles after the start edge, then checks DECIDE and HOLD entry.
  task automatic accum_and_check(input int mode, input int ew, input int et, input int c0, input int c1);
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clk);
      start  = (k == 20);
      ready  = 1'b0;
      spikes = gen(mode, k);
      if (k == 0) check("busy_accum", int'(busy), 1);
      if (k == 0) check("valid_accum", int'(valid), 0);
    end
    @(negedge clk);
    start  = 1'b0;
    spikes = 2'b00;
    check("busy_decide", int'(busy), 1);
    check("valid_decide", int'(valid), 0);
    @(negedge clk);
    check("valid_hold", int'(valid), 1);
    check("busy_hold", int'(busy), 0);
    check("winner", int'(winner), ew);
    check("tie", int'(tie), et);
`ifdef CLASSIFIER_COUNTS_OUT_EN
    check("count0", int'(counts[7:0]), c0);
    check("count1", int'(counts[15:8]), c1);
`endif
  endtask

  // Start cycle carries a neuron-1 spike that must not be counted.
  task automatic run_window(input int mode, input int ew, input int et, input int c0, input int c1);
    @(negedge clk);
    start  = 1'b1;
    spikes = 2'b10;
    accum_and_check(mode, ew, et, c0, c1);
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("valid_after_accept", int'(valid), 0);
    check("busy_after_accept", int'(busy), 0);
  endtask

  task automatic run_sat(input int mode, input int ew, input int et);
    @(negedge clk);
    start2  = 1'b1;
    spikes2 = 2'b11;
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clk);
      start2  = 1'b0;
      spikes2 = gen(mode, k);
    end
    @(negedge clk);
    spikes2 = 2'b00;
    @(negedge clk);
    check("sat_valid", int'(valid2), 1);
    check("sat_winner", int'(winner2), ew);
    check("sat_tie", int'(tie2), et);
`ifdef CLASSIFIER_COUNTS_OUT_EN
    check("sat_count0", int'(counts2[3:0]), 15);
    check("sat_count1", int'(counts2[7:4]), 15);
`endif
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    check("sat_valid_after_accept", int'(valid2), 0);
  endtask

  initial begin
    logic [0:0] held_w;
    logic       held_t;

    vecs[0] = '{0, 0, 0, 64, 0};
    vecs[1] = '{1, 1, 0, 16, 32};
    vecs[2] = '{2, 0, 1, 0, 0};
    vecs[3] = '{3, 1, 0, 0, 64};
    vecs[4] = '{4, 0, 1, 64, 64};
    vecs[5] = '{5, 0, 1, 40, 40};
    vecs[6] = '{6, 1, 0, 40, 41};

    reset   = 1'b1;
    start   = 1'b0;
    start2  = 1'b0;
    spikes  = 2'b00;
    spikes2 = 2'b00;
    ready   = 1'b0;
    ready2  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_tie", int'(tie), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      run_window(vecs[i].mode, vecs[i].exp_winner, vecs[i].exp_tie, vecs[i].exp_c0, vecs[i].exp_c1);
      accept();
      check("winner_kept_after_accept", int'(winner), vecs[i].exp_winner);
    end

    // Reset 30 cycles into a window; winner is 1 from the last vector.
    @(negedge clk);
    start  = 1'b1;
    spikes = 2'b10;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      start  = 1'b0;
      spikes = 2'b11;
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_winner", int'(winner), 0);
    check("midrst_tie", int'(tie), 0);
    @(negedge clk);
    reset  = 1'b0;
    spikes = 2'b00;
    run_window(5, 0, 1, 40, 40);
    accept();

    // Back-pressure in HOLD, start ignored, then back-to-back window on the handshake.
    run_window(1, 1, 0, 16, 32);
    held_w = winner;
    held_t = tie;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k % 2 == 0);
      check("hold_valid", int'(valid), 1);
      check("hold_busy", int'(busy), 0);
      check("hold_winner", int'(winner), 1);
      check("hold_tie", int'(tie), 0);
    end
    check("hold_stable", int'({held_w, held_t}), int'({winner, tie}));
    @(negedge clk);
    start  = 1'b1;
    ready  = 1'b1;
    spikes = 2'b10;
    accum_and_check(2, 0, 1, 0, 0);
    accept();

    run_sat(4, 0, 1);
    run_sat(7, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
